// File: rtl/parking_pkg.sv
// Shared definitions for the parking subsystem: spot count, index width and
// small arithmetic helpers used by the fee meter and the capacity logic.
package parking_pkg;

    localparam int unsigned NUM_SPOTS = 4;
    localparam int unsigned SPOT_W    = 2;

    typedef logic [SPOT_W-1:0]    spot_idx_t;
    typedef logic [NUM_SPOTS-1:0] spot_vec_t;

    // Clamp an unsigned value to the largest number representable in 'width'
    // bits (width <= 32). Callers size the result down to 'width'.
    function automatic logic [31:0] sat_limit(input logic [63:0] value,
                                              input int unsigned width);
        logic [63:0] lim;
        lim = (64'd1 << width) - 64'd1;
        return (value > lim) ? lim[31:0] : value[31:0];
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic spot_idx_t lowest_index(input spot_vec_t v);
        spot_idx_t idx;
        idx = '0;
        for (int unsigned k = NUM_SPOTS; k > 0; k--) begin
            if (v[k-1]) begin
                idx = SPOT_W'(k - 1);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts 0..TICK_DIV-1 and flags the final count as a
// one-cycle tick. Synchronous reset restarts the phase at 0.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap to zero after the last count.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    // Count register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/parking_fee_meter.sv
// Per-spot dwell timing and billing. Each vacated spot leaves a pending
// record holding its dwell snapshot; records are served lowest index first,
// one per cycle, as a fee strobe, and summed into a saturating revenue total.
module parking_fee_meter
    import parking_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned GRACE    = 2,
    parameter int unsigned RATE     = 3,
    parameter int unsigned FEE_W    = 12,
    parameter int unsigned REV_W    = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_SPOTS-1:0] E,
    input  logic                 rev_clr,
    output logic [FEE_W-1:0]     fee,
    output logic [SPOT_W-1:0]    fee_spot,
    output logic                 fee_valid,
    output logic [REV_W-1:0]     revenue,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned RATE_W = (RATE > 0) ? $clog2(RATE + 1) : 1;
    localparam int unsigned PROD_W = CNT_W + RATE_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                       tick;
    logic [NUM_SPOTS-1:0]       e_q;
    logic [NUM_SPOTS-1:0]       rise;
    logic [NUM_SPOTS-1:0]       fall;
    logic [NUM_SPOTS*CNT_W-1:0] snap_flat;

    logic [NUM_SPOTS-1:0] pending_q, pending_d;
    logic                 busy_q;
    logic                 overrun_q, overrun_d;
    logic [FEE_W-1:0]     fee_q, fee_d;
    logic [SPOT_W-1:0]    fee_spot_q, fee_spot_d;
    logic                 fee_valid_q, fee_valid_d;
    logic [REV_W-1:0]     revenue_q, revenue_d;

    logic                 serve;
    logic [SPOT_W-1:0]    sel;
    logic [NUM_SPOTS-1:0] serve_mask;
    logic [CNT_W-1:0]     snap_sel;
    logic [CNT_W-1:0]     billed;
    logic [PROD_W-1:0]    product;
    logic [FEE_W-1:0]     fee_calc;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .CLK  (CLK),
        .RST  (RST),
        .tick (tick)
    );

    // Previous occupancy, for edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            e_q <= '0;
        end else begin
            e_q <= E;
        end
    end

    assign rise = E & ~e_q;
    assign fall = ~E & e_q;

    for (genvar i = 0; i < NUM_SPOTS; i++) begin : g_spot
        logic [CNT_W-1:0] dwell_q, dwell_d;
        logic [CNT_W-1:0] snap_q, snap_d;

        // Dwell: arrival restarts, ticks while occupied advance (saturating);
        // a departure freezes the pre-tick value into the snapshot.
        always_comb begin
            dwell_d = dwell_q;
            if (rise[i]) begin
                dwell_d = '0;
            end else if (tick && e_q[i] && !fall[i] && (dwell_q != CNT_MAX)) begin
                dwell_d = dwell_q + CNT_W'(1);
            end
            snap_d = fall[i] ? dwell_q : snap_q;
        end

        // Per-spot dwell and snapshot registers.
        always_ff @(posedge CLK) begin
            if (RST) begin
                dwell_q <= '0;
                snap_q  <= '0;
            end else begin
                dwell_q <= dwell_d;
                snap_q  <= snap_d;
            end
        end

        assign snap_flat[i*CNT_W +: CNT_W] = snap_q;
    end

    // Service selection, fee computation, pending/overrun and revenue update.
    always_comb begin
        serve      = |pending_q;
        sel        = lowest_index(pending_q);
        serve_mask = '0;
        if (serve) begin
            serve_mask[sel] = 1'b1;
        end

        snap_sel = snap_flat[sel*CNT_W +: CNT_W];
        billed   = '0;
        if (32'(snap_sel) > GRACE) begin
            billed = snap_sel - CNT_W'(GRACE);
        end
        product  = PROD_W'(billed) * PROD_W'(RATE);
        fee_calc = FEE_W'(sat_limit(64'(product), FEE_W));

        // A departure in the serving cycle re-arms the record (set wins).
        pending_d = (pending_q & ~serve_mask) | fall;
        overrun_d = overrun_q | (|(fall & pending_q & ~serve_mask));

        fee_valid_d = serve;
        fee_d       = serve ? fee_calc : fee_q;
        fee_spot_d  = serve ? sel : fee_spot_q;

        if (rev_clr) begin
            revenue_d = fee_valid_q ? REV_W'(sat_limit(64'(fee_q), REV_W)) : '0;
        end else if (fee_valid_q) begin
            revenue_d = REV_W'(sat_limit(64'(revenue_q) + 64'(fee_q), REV_W));
        end else begin
            revenue_d = revenue_q;
        end
    end

    // Output and bookkeeping registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending_q   <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            fee_q       <= '0;
            fee_spot_q  <= '0;
            fee_valid_q <= 1'b0;
            revenue_q   <= '0;
        end else begin
            pending_q   <= pending_d;
            busy_q      <= |pending_d;
            overrun_q   <= overrun_d;
            fee_q       <= fee_d;
            fee_spot_q  <= fee_spot_d;
            fee_valid_q <= fee_valid_d;
            revenue_q   <= revenue_d;
        end
    end

    assign fee       = fee_q;
    assign fee_spot  = fee_spot_q;
    assign fee_valid = fee_valid_q;
    assign revenue   = revenue_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_parking_fee_meter.sv
// Directed bench for parking_fee_meter. Main instance uses TICK_DIV=4; two
// narrow instances (TICK_DIV=1) exercise dwell, fee and revenue saturation.
// Cycle n after reset release has prescaler count (n-1)%TICK_DIV.
module tb_parking_fee_meter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  E = '0;
    logic        rev_clr = 1'b0;
    logic [11:0] fee;
    logic [1:0]  fee_spot;
    logic        fee_valid;
    logic [15:0] revenue;
    logic        busy;
    logic        overrun;

    logic        RST_s = 1'b1;
    logic [3:0]  E_s = '0;
    logic        rev_clr_s = 1'b0;
    logic [11:0] fee_b;
    logic [1:0]  fee_spot_b;
    logic        fee_valid_b;
    logic [15:0] revenue_b;
    logic        busy_b;
    logic        overrun_b;
    logic [4:0]  fee_c;
    logic [1:0]  fee_spot_c;
    logic        fee_valid_c;
    logic [5:0]  revenue_c;
    logic        busy_c;
    logic        overrun_c;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 CLK = ~CLK;

    parking_fee_meter #(
        .TICK_DIV (4), .CNT_W (8), .GRACE (2), .RATE (3), .FEE_W (12), .REV_W (16)
    ) dut (
        .CLK (CLK), .RST (RST), .E (E), .rev_clr (rev_clr),
        .fee (fee), .fee_spot (fee_spot), .fee_valid (fee_valid),
        .revenue (revenue), .busy (busy), .overrun (overrun)
    );

    parking_fee_meter #(
        .TICK_DIV (1), .CNT_W (4), .GRACE (2), .RATE (3), .FEE_W (12), .REV_W (16)
    ) dut_b (
        .CLK (CLK), .RST (RST_s), .E (E_s), .rev_clr (rev_clr_s),
        .fee (fee_b), .fee_spot (fee_spot_b), .fee_valid (fee_valid_b),
        .revenue (revenue_b), .busy (busy_b), .overrun (overrun_b)
    );

    parking_fee_meter #(
        .TICK_DIV (1), .CNT_W (4), .GRACE (2), .RATE (3), .FEE_W (5), .REV_W (6)
    ) dut_c (
        .CLK (CLK), .RST (RST_s), .E (E_s), .rev_clr (rev_clr_s),
        .fee (fee_c), .fee_spot (fee_spot_c), .fee_valid (fee_valid_c),
        .revenue (revenue_c), .busy (busy_c), .overrun (overrun_c)
    );

    task automatic clk(input int unsigned n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        E = '0;
        rev_clr = 1'b0;
        clk(2);
        RST = 1'b0;
    endtask

    initial begin
        int unsigned rev_b_exp [3];
        int unsigned rev_c_exp [3];
        rev_b_exp = '{39, 78, 117};
        rev_c_exp = '{31, 62, 63};

        // Reset state.
        do_reset();
        chk("rst_fee", 32'(fee), 0);
        chk("rst_fee_spot", 32'(fee_spot), 0);
        chk("rst_fee_valid", 32'(fee_valid), 0);
        chk("rst_revenue", 32'(revenue), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);

        // Basic departure: spot 0 held cycles 1..20, ticks at 4,8,..,20 -> dwell 5.
        E = 4'b0001;
        clk(20);
        E = 4'b0000;
        clk(1);
        chk("basic_busy", 32'(busy), 1);
        chk("basic_fv_early", 32'(fee_valid), 0);
        clk(1);
        chk("basic_fv", 32'(fee_valid), 1);
        chk("basic_fee", 32'(fee), 9);
        chk("basic_spot", 32'(fee_spot), 0);
        chk("basic_busy_done", 32'(busy), 0);
        clk(1);
        chk("basic_fv_drop", 32'(fee_valid), 0);
        chk("basic_revenue", 32'(revenue), 9);
        chk("basic_fee_hold", 32'(fee), 9);

        // Grace: spot 2 held cycles 24..28, one tick (28) -> dwell 1, fee 0.
        E = 4'b0100;
        clk(5);
        E = 4'b0000;
        clk(2);
        chk("grace_fv", 32'(fee_valid), 1);
        chk("grace_fee", 32'(fee), 0);
        chk("grace_spot", 32'(fee_spot), 2);
        clk(1);
        chk("grace_revenue", 32'(revenue), 9);

        // Simultaneous departures: spots 0,1,3 for 8 ticks -> fee 18 each.
        do_reset();
        E = 4'b1011;
        clk(32);
        E = 4'b0000;
        clk(1);
        chk("sim_busy0", 32'(busy), 1);
        chk("sim_fv0", 32'(fee_valid), 0);
        clk(1);
        chk("sim_fv1", 32'(fee_valid), 1);
        chk("sim_spot1", 32'(fee_spot), 0);
        chk("sim_fee1", 32'(fee), 18);
        chk("sim_busy1", 32'(busy), 1);
        clk(1);
        chk("sim_fv2", 32'(fee_valid), 1);
        chk("sim_spot2", 32'(fee_spot), 1);
        chk("sim_fee2", 32'(fee), 18);
        chk("sim_busy2", 32'(busy), 1);
        chk("sim_rev2", 32'(revenue), 18);
        clk(1);
        chk("sim_fv3", 32'(fee_valid), 1);
        chk("sim_spot3", 32'(fee_spot), 3);
        chk("sim_fee3", 32'(fee), 18);
        chk("sim_busy3", 32'(busy), 0);
        chk("sim_rev3", 32'(revenue), 36);
        clk(1);
        chk("sim_fv_end", 32'(fee_valid), 0);
        chk("sim_revenue", 32'(revenue), 54);

        // Clear in the same cycle as a fee=9 strobe: spot 0 cycles 38..57.
        E = 4'b0001;
        clk(20);
        E = 4'b0000;
        clk(2);
        chk("clr_fv", 32'(fee_valid), 1);
        chk("clr_fee", 32'(fee), 9);
        rev_clr = 1'b1;
        clk(1);
        rev_clr = 1'b0;
        chk("clr_revenue", 32'(revenue), 9);

        // Reset with spots 0 and 2 pending.
        E = 4'b0101;
        clk(3);
        E = 4'b0000;
        clk(1);
        chk("rstmid_busy", 32'(busy), 1);
        RST = 1'b1;
        clk(1);
        RST = 1'b0;
        chk("rstmid_fee", 32'(fee), 0);
        chk("rstmid_spot", 32'(fee_spot), 0);
        chk("rstmid_fv", 32'(fee_valid), 0);
        chk("rstmid_revenue", 32'(revenue), 0);
        chk("rstmid_busy0", 32'(busy), 0);
        chk("rstmid_overrun", 32'(overrun), 0);
        for (int i = 0; i < 8; i++) begin
            clk(1);
            chk("rstmid_no_fee", 32'(fee_valid), 0);
        end

        // Re-entry/overrun on spot 2, kept queued by spots 0 and 1.
        // Cycles 9..32 occupied, ticks 12..32 -> dwell 6 (fee 12).
        E = 4'b0111;
        clk(24);
        E = 4'b0000;
        clk(1);
        E = 4'b0100;
        clk(1);
        chk("ovr_spot_a", 32'(fee_spot), 0);
        chk("ovr_fee_a", 32'(fee), 12);
        chk("ovr_flag_a", 32'(overrun), 0);
        E = 4'b0000;
        clk(1);
        chk("ovr_spot_b", 32'(fee_spot), 1);
        chk("ovr_fee_b", 32'(fee), 12);
        chk("ovr_flag_b", 32'(overrun), 1);
        clk(1);
        chk("ovr_spot_c", 32'(fee_spot), 2);
        chk("ovr_fee_c", 32'(fee), 0);
        chk("ovr_fv_c", 32'(fee_valid), 1);
        chk("ovr_busy_c", 32'(busy), 0);
        clk(5);
        chk("ovr_sticky", 32'(overrun), 1);
        chk("ovr_revenue", 32'(revenue), 24);
        RST = 1'b1;
        clk(1);
        RST = 1'b0;
        chk("ovr_cleared", 32'(overrun), 0);

        // Saturation: CNT_W=4 -> dwell 15, fee 39; FEE_W=5 -> 31; REV_W=6 -> 63.
        RST_s = 1'b1;
        clk(2);
        RST_s = 1'b0;
        for (int d = 0; d < 3; d++) begin
            E_s = 4'b0001;
            clk(40);
            E_s = 4'b0000;
            clk(2);
            chk("sat_fv_b", 32'(fee_valid_b), 1);
            chk("sat_fee_b", 32'(fee_b), 39);
            chk("sat_fee_c", 32'(fee_c), 31);
            clk(1);
            chk("sat_rev_b", 32'(revenue_b), rev_b_exp[d]);
            chk("sat_rev_c", 32'(revenue_c), rev_c_exp[d]);
        end
        chk("sat_spot_c", 32'(fee_spot_c), 0);
        chk("sat_busy_b", 32'(busy_b), 0);
        chk("sat_overrun_c", 32'(overrun_c), 0);
        rev_clr_s = 1'b1;
        clk(1);
        rev_clr_s = 1'b0;
        chk("sat_clr_b", 32'(revenue_b), 0);
        chk("sat_clr_c", 32'(revenue_c), 0);
        chk("sat_fv_c_idle", 32'(fee_valid_c), 0);
        chk("sat_spot_b", 32'(fee_spot_b), 0);
        chk("sat_overrun_b", 32'(overrun_b), 0);
        chk("sat_busy_c", 32'(busy_c), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
